// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encoding and default width shared by the univ_shift_reg slice.
package usr_pkg;
   typedef enum logic [1:0] {
      USR_HOLD   = 2'b00,
      USR_SHL_UP = 2'b01,
      USR_SHR_DN = 2'b10,
      USR_ROT_UP = 2'b11
   } usr_mode_e;
   localparam int USR_DEF_WIDTH = 8;
endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and status bundle of univ_shift_reg; optional par under USR_PARITY_EN.
interface univ_shift_reg_if import usr_pkg::*; #(parameter int WIDTH = USR_DEF_WIDTH);
   localparam int CNT_W = $clog2(WIDTH);
   logic             ce_n;
   logic             pl_n;
   usr_mode_e        mode;
   logic [WIDTH-1:0] p;
   logic             dsr;
   logic             dsl;
   logic [WIDTH-1:0] q;
   logic             q7;
   logic             q7_n;
   logic             q0;
   logic [CNT_W-1:0] cnt;
   logic             done;
`ifdef USR_PARITY_EN
   logic             par;
`endif
   modport master (
      output ce_n, pl_n, mode, p, dsr, dsl,
      input  q, q7, q7_n, q0, cnt, done
`ifdef USR_PARITY_EN
      , input par
`endif
   );
   modport slave (
      input  ce_n, pl_n, mode, p, dsr, dsl,
      output q, q7, q7_n, q0, cnt, done
`ifdef USR_PARITY_EN
      , output par
`endif
   );
endinterface

// File: rtl/univ_shift_reg_cnt.sv
// usr_shift_cnt: modulo-WIDTH shift counter; done pulses on the shift that completes a word.
module usr_shift_cnt #(
   parameter int WIDTH = 8
) (
   input  logic                     cp,
   input  logic                     mr_n,
   input  logic                     clr,
   input  logic                     inc,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     done
);
   localparam int CNT_W = $clog2(WIDTH);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             last;
   always_comb begin
      last   = cnt_q == CNT_W'(WIDTH - 1);
      cnt_d  = clr ? '0 : !inc ? cnt_q : last ? '0 : cnt_q + CNT_W'(1);
      done_d = !clr && inc && last;
   end
   always_ff @(posedge cp) begin
      if (!mr_n) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end
   assign cnt  = cnt_q;
   assign done = done_q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with load, 4 shift modes and word-done pulse.
// Optional registered even-parity output par when USR_PARITY_EN is defined.
module univ_shift_reg import usr_pkg::*; #(
   parameter int WIDTH = USR_DEF_WIDTH
) (
   input logic              cp,
   input logic              mr_n,
   univ_shift_reg_if.slave  bus
);
   logic [WIDTH-1:0] q_q, q_d, sh;
   logic             inc;
   always_comb begin
      sh  = bus.mode == USR_SHL_UP ? {q_q[WIDTH-2:0], bus.dsr} :
            bus.mode == USR_SHR_DN ? {bus.dsl, q_q[WIDTH-1:1]} :
                                     {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      inc = bus.pl_n && !bus.ce_n && bus.mode != USR_HOLD;
      q_d = !bus.pl_n ? bus.p : inc ? sh : q_q;
   end
   always_ff @(posedge cp) begin
      if (!mr_n) q_q <= '0;
      else       q_q <= q_d;
   end
   usr_shift_cnt #(.WIDTH(WIDTH)) u_cnt (
      .cp   (cp),
      .mr_n (mr_n),
      .clr  (!bus.pl_n),
      .inc  (inc),
      .cnt  (bus.cnt),
      .done (bus.done)
   );
   assign bus.q    = q_q;
   assign bus.q7   = q_q[WIDTH-1];
   assign bus.q7_n = ~q_q[WIDTH-1];
   assign bus.q0   = q_q[0];
`ifdef USR_PARITY_EN
   // q_d equals q_q when nothing changes, so tracking q_d keeps par held on idle cycles
   logic par_q;
   always_ff @(posedge cp) begin
      if (!mr_n) par_q <= 1'b0;
      else       par_q <= ^q_d;
   end
   assign bus.par = par_q;
`endif
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed plus random stimulus against an arithmetic model of univ_shift_reg (WIDTH=8).
module tb_univ_shift_reg;
   import usr_pkg::*;
   logic cp = 1'b0;
   logic mr_n;
   int   total = 0;
   int   passed = 0;
   int   fails = 0;
   int   m_q = 0;
   int   m_n = 0;
   int   m_done = 0;
   int   done_seen;
   univ_shift_reg_if #(.WIDTH(8)) bus ();
   univ_shift_reg #(.WIDTH(8)) dut (
      .cp   (cp),
      .mr_n (mr_n),
      .bus  (bus)
   );
   always #5 cp = ~cp;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input string tag, input bit mr, input bit pl, input bit ce,
                      input int md, input logic [7:0] pp, input bit sr, input bit sl);
      int v;
      mr_n     = mr;
      bus.pl_n = pl;
      bus.ce_n = ce;
      bus.mode = usr_mode_e'(md[1:0]);
      bus.p    = pp;
      bus.dsr  = sr;
      bus.dsl  = sl;
      @(posedge cp);
      if (!mr) begin
         m_q = 0; m_n = 0; m_done = 0;
      end else if (!pl) begin
         m_q = int'(pp); m_n = 0; m_done = 0;
      end else if (ce || md == 0) begin
         m_done = 0;
      end else begin
         v = m_q;
         if (md == 1)      v = (v * 2 + int'(sr)) % 256;
         else if (md == 2) v = v / 2 + int'(sl) * 128;
         else              v = (v * 2) % 256 + v / 128;
         m_q = v;
         m_n++;
         m_done = (m_n == 8) ? 1 : 0;
         if (m_n == 8) m_n = 0;
      end
      #1;
      chk({tag, " q"},    32'(bus.q),    32'(m_q));
      chk({tag, " q7"},   32'(bus.q7),   32'(m_q / 128));
      chk({tag, " q7_n"}, 32'(bus.q7_n), 32'(1 - m_q / 128));
      chk({tag, " q0"},   32'(bus.q0),   32'(m_q % 2));
      chk({tag, " cnt"},  32'(bus.cnt),  32'(m_n));
      chk({tag, " done"}, 32'(bus.done), 32'(m_done));
`ifdef USR_PARITY_EN
      chk({tag, " par"},  32'(bus.par),  32'($countones(m_q) % 2));
`endif
      if (bus.done === 1'b1) done_seen++;
   endtask
   initial begin
      cyc("reset_beats_load", 0, 0, 0, 1, 8'hFF, 1, 1);
      chk("reset q", 32'(bus.q), 32'h00);
      chk("reset q7_n", 32'(bus.q7_n), 32'h1);
      cyc("load_a5", 1, 0, 0, 1, 8'hA5, 0, 0);
      done_seen = 0;
      for (int i = 0; i < 8; i++) cyc("shl_a5", 1, 1, 0, 1, 8'h00, 0, 0);
      chk("shl_a5 final q", 32'(bus.q), 32'h00);
      chk("shl_a5 final done", 32'(bus.done), 32'h1);
      chk("shl_a5 final cnt", 32'(bus.cnt), 32'h0);
      chk("shl_a5 done count", 32'(done_seen), 32'h1);
      cyc("post_word", 1, 1, 1, 1, 8'h00, 0, 0);
      cyc("load_00", 1, 0, 0, 2, 8'h00, 0, 1);
      for (int i = 0; i < 3; i++) cyc("shr_fill", 1, 1, 0, 2, 8'h00, 0, 1);
      chk("shr_fill q", 32'(bus.q), 32'hE0);
      chk("shr_fill cnt", 32'(bus.cnt), 32'h3);
      cyc("load_81", 1, 0, 0, 3, 8'h81, 0, 0);
      done_seen = 0;
      for (int i = 0; i < 16; i++) cyc("rot_gated", 1, 1, i % 2, 3, 8'h00, 1, 1);
      chk("rot_gated q", 32'(bus.q), 32'h81);
      chk("rot_gated done count", 32'(done_seen), 32'h1);
      done_seen = 0;
      for (int i = 0; i < 5; i++) cyc("shl5", 1, 1, 0, 1, 8'h00, 1, 0);
      cyc("load_over_shift", 1, 0, 0, 1, 8'h3C, 1, 0);
      chk("load_over_shift q", 32'(bus.q), 32'h3C);
      for (int i = 0; i < 3; i++) cyc("shl3", 1, 1, 0, 1, 8'h00, 0, 0);
      cyc("abort_reset", 0, 1, 0, 1, 8'h00, 0, 0);
      chk("abort cnt", 32'(bus.cnt), 32'h0);
      chk("abort no done", 32'(done_seen), 32'h0);
      cyc("mixed_load", 1, 0, 0, 0, 8'h5A, 0, 0);
      for (int i = 0; i < 8; i++) cyc("mixed_updown", 1, 1, 0, 1 + i % 2, 8'h00, i % 3 == 0, 1);
      chk("mixed done", 32'(bus.done), 32'h1);
`ifdef USR_PARITY_EN
      cyc("par_load07", 1, 0, 0, 0, 8'h07, 0, 0);
      chk("par 07", 32'(bus.par), 32'h1);
      cyc("par_shl", 1, 1, 0, 1, 8'h00, 0, 0);
      chk("par 0e q", 32'(bus.q), 32'h0E);
      chk("par 0e", 32'(bus.par), 32'h1);
      cyc("par_load03", 1, 0, 0, 0, 8'h03, 0, 0);
      chk("par 03", 32'(bus.par), 32'h0);
`endif
      for (int i = 0; i < 400; i++)
         cyc("random", $urandom_range(0, 31) != 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
             8'($urandom), 1'($urandom), 1'($urandom));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
